// File: rtl/alu_cmd_sequencer.sv
// Command front-end and writeback stage around an external 4-bit combinational ALU.
// Latency: response valid two edges after command accept; one command in flight at a time.
// Backpressure: cmd_ready only in IDLE; response held stable in RESP until rsp_ready.
module alu_cmd_sequencer #(
    parameter int DATA_W = 4,
    parameter int NREGS  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_load,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_src_a,
    input  logic [ADDR_W-1:0] cmd_src_b,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_opcode,
    input  logic [DATA_W:0]   alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W:0]   rsp_result,
    output logic              rsp_carry,
    output logic              rsp_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;

    // Latched command fields; operands are snapshotted from the register file at
    // accept so the ALU inputs stay put even when the writeback hits a source register.
    logic                load_q;
    logic [2:0]          op_q;
    logic [ADDR_W-1:0]   dst_q;
    logic [DATA_W-1:0]   imm_q;
    logic [DATA_W-1:0]   alu_a_q;
    logic [DATA_W-1:0]   alu_b_q;

    logic [DATA_W-1:0]   rf_q [NREGS];

    logic [DATA_W:0]     rsp_result_q;
    logic                rsp_carry_q;
    logic                rsp_zero_q;

    logic                accept;
    logic [DATA_W:0]     exec_res_d;

    assign cmd_ready  = (state_q == S_IDLE);
    assign rsp_valid  = (state_q == S_RESP);
    assign accept     = cmd_ready && cmd_valid;

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = op_q;

    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_zero   = rsp_zero_q;

    // Result selection for the closing edge of EXEC: loads bypass the ALU.
    always_comb begin
        exec_res_d = alu_result;
        if (load_q) begin
            exec_res_d = {1'b0, imm_q};
        end
    end

    // Next-state logic: IDLE -> EXEC on accept, EXEC is always one cycle, RESP waits for handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_valid) state_d = S_EXEC;
            S_EXEC:  state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, command latch, register file and response registers; reset drops any in-flight command.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            load_q       <= 1'b0;
            op_q         <= '0;
            dst_q        <= '0;
            imm_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (accept) begin
                load_q  <= cmd_load;
                op_q    <= cmd_op;
                dst_q   <= cmd_dst;
                imm_q   <= cmd_imm;
                alu_a_q <= rf_q[cmd_src_a];
                alu_b_q <= rf_q[cmd_src_b];
            end
            if (state_q == S_EXEC) begin
                rf_q[dst_q]  <= exec_res_d[DATA_W-1:0];
                rsp_result_q <= exec_res_d;
                rsp_carry_q  <= exec_res_d[DATA_W];
                rsp_zero_q   <= (exec_res_d[DATA_W-1:0] == '0);
            end
        end
    end

endmodule
